// File: rtl/vector_result_writeback_buffer.sv
// In-order result buffer between the vector execution units and the VRF write port.
// First-word-fall-through head, combinational RAW-hazard query over buffered entries.
module vector_result_writeback_buffer #(
  parameter int VLEN           = 128,
  parameter int DEPTH          = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      result_valid,
  output logic                      result_ready,
  input  logic [VLEN-1:0]           result_vd,
  input  logic [REG_ADDR_WIDTH-1:0] result_address,
  input  logic [VLEN/8-1:0]         result_byte_enable,
  output logic                      write_valid,
  input  logic                      write_ready,
  output logic [VLEN-1:0]           write_data,
  output logic [REG_ADDR_WIDTH-1:0] write_address,
  output logic [VLEN/8-1:0]         write_byte_enable,
  input  logic [REG_ADDR_WIDTH-1:0] query_address,
  output logic                      query_pending,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [VLEN-1:0]           data_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [VLEN/8-1:0]         be_q   [DEPTH];
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          occ_q, occ_d;
  logic                      push_s, pop_s, full_s, empty_s, pending_s;

  assign full_s  = (occ_q == CNT_W'(DEPTH));
  assign empty_s = (occ_q == {CNT_W{1'b0}});
  assign push_s  = result_valid && !full_s;
  assign pop_s   = !empty_s && write_ready;

  // Pointer, occupancy and valid-bit next state; flush discards everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    valid_d  = valid_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      occ_d    = {CNT_W{1'b0}};
      valid_d  = {DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {CNT_W{1'b0}};
      valid_q  <= {DEPTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage is left unreset; outputs are gated by empty instead
  always_ff @(posedge clock) begin
    if (push_s && !flush && !reset) begin
      data_q[wr_ptr_q] <= result_vd;
      addr_q[wr_ptr_q] <= result_address;
      be_q[wr_ptr_q]   <= result_byte_enable;
    end
  end

  // Hazard match over stored entries only; an entry being pushed is not yet visible
  always_comb begin
    pending_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == query_address)) begin
        pending_s = 1'b1;
      end else begin
        pending_s = pending_s;
      end
    end
  end

  assign result_ready      = !full_s;
  assign write_valid       = !empty_s;
  assign write_data        = empty_s ? {VLEN{1'b0}} : data_q[rd_ptr_q];
  assign write_address     = empty_s ? {REG_ADDR_WIDTH{1'b0}} : addr_q[rd_ptr_q];
  assign write_byte_enable = empty_s ? {(VLEN/8){1'b0}} : be_q[rd_ptr_q];
  assign query_pending     = pending_s;
  assign occupancy         = occ_q;
  assign full              = full_s;
  assign empty             = empty_s;

endmodule

// File: tb/tb_vector_result_writeback_buffer.sv
// Directed, table-driven bench for vector_result_writeback_buffer with hand-computed expectations.
module tb_vector_result_writeback_buffer;

  localparam int VLEN = 128;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int BW = VLEN / 8;

  logic          clock = 1'b0;
  logic          reset, flush, result_valid, result_ready, write_valid, write_ready;
  logic [VLEN-1:0] result_vd, write_data;
  logic [AW-1:0] result_address, write_address, query_address;
  logic [BW-1:0] result_byte_enable, write_byte_enable;
  logic          query_pending, full, empty;
  logic [2:0]    occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  vector_result_writeback_buffer #(.VLEN(VLEN), .DEPTH(DEPTH), .REG_ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_vd(result_vd), .result_address(result_address),
    .result_byte_enable(result_byte_enable),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_data(write_data), .write_address(write_address),
    .write_byte_enable(write_byte_enable),
    .query_address(query_address), .query_pending(query_pending),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  typedef struct {
    logic       fl;
    logic       rv;
    logic [4:0] ra;
    logic       wr;
    logic [4:0] qa;
    logic       e_rr;
    logic       e_wv;
    logic [4:0] e_wa;
    logic [2:0] e_occ;
    logic       e_qp;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [127:0] vd_of(input logic [4:0] a);
    return {16{3'b101, a}};
  endfunction

  // address 13 carries an all-zero byte enable
  function automatic logic [15:0] be_of(input logic [4:0] a);
    return (a == 5'd13) ? 16'h0000 : {a, a, a, 1'b1};
  endfunction

  function automatic vec_t mk(input logic fl, input logic rv, input logic [4:0] ra,
                              input logic wr, input logic [4:0] qa, input logic e_rr,
                              input logic e_wv, input logic [4:0] e_wa,
                              input logic [2:0] e_occ, input logic e_qp);
    vec_t v;
    v.fl = fl; v.rv = rv; v.ra = ra; v.wr = wr; v.qa = qa;
    v.e_rr = e_rr; v.e_wv = e_wv; v.e_wa = e_wa; v.e_occ = e_occ; v.e_qp = e_qp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic rv, input logic [4:0] ra,
                       input logic wr, input logic [4:0] qa);
    flush = fl;
    result_valid = rv;
    result_address = ra;
    result_vd = vd_of(ra);
    result_byte_enable = be_of(ra);
    write_ready = wr;
    query_address = qa;
  endtask

  task automatic chk_head(input string tag, input logic e_wv, input logic [4:0] e_wa,
                          input logic [2:0] e_occ);
    chk({tag, " write_valid"}, write_valid, e_wv);
    chk({tag, " write_address"}, write_address, e_wv ? e_wa : 5'd0);
    chk({tag, " write_data"}, write_data, e_wv ? vd_of(e_wa) : 128'd0);
    chk({tag, " write_byte_enable"}, write_byte_enable, e_wv ? be_of(e_wa) : 16'd0);
    chk({tag, " occupancy"}, occupancy, e_occ);
    chk({tag, " full"}, full, e_occ == 3'd4);
    chk({tag, " empty"}, empty, e_occ == 3'd0);
  endtask

  initial begin
    // fill to full with write_ready low, refused 5th push, then in-order drain
    tbl[0]  = mk(1'b0, 1'b1, 5'd1,  1'b0, 5'd0,  1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 5'd2,  1'b0, 5'd0,  1'b1, 1'b1, 5'd1, 3'd1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 1'b1, 5'd1, 3'd2, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 5'd4,  1'b0, 5'd0,  1'b1, 1'b1, 5'd1, 3'd3, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 1'b1, 5'd1, 3'd4, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 5'd0,  1'b0, 5'd9,  1'b0, 1'b1, 5'd1, 3'd4, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 5'd0,  1'b1, 5'd4,  1'b0, 1'b1, 5'd1, 3'd4, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 5'd0,  1'b1, 5'd1,  1'b1, 1'b1, 5'd2, 3'd3, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 5'd0,  1'b1, 5'd4,  1'b1, 1'b1, 5'd3, 3'd2, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 5'd0,  1'b1, 5'd4,  1'b1, 1'b1, 5'd4, 3'd1, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 5'd0,  1'b1, 5'd4,  1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
    // hazard query: 7, 7, 3
    tbl[11] = mk(1'b0, 1'b1, 5'd7,  1'b0, 5'd7,  1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 5'd7,  1'b0, 5'd7,  1'b1, 1'b1, 5'd7, 3'd1, 1'b1);
    tbl[13] = mk(1'b0, 1'b1, 5'd3,  1'b0, 5'd12, 1'b1, 1'b1, 5'd7, 3'd2, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b1, 1'b1, 5'd7, 3'd3, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b1, 1'b1, 5'd7, 3'd2, 1'b1);
    tbl[16] = mk(1'b0, 1'b0, 5'd0,  1'b0, 5'd7,  1'b1, 1'b1, 5'd3, 3'd1, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 5'd0,  1'b1, 5'd12, 1'b1, 1'b1, 5'd3, 3'd1, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 5'd0, 3'd0, 1'b0);

    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk_head("reset", 1'b0, 5'd0, 3'd0);
    chk("reset result_ready", result_ready, 1'b1);
    chk("reset query_pending", query_pending, 1'b0);

    // single push: not visible in the offering cycle, presented the next
    @(negedge clock);
    drive(1'b0, 1'b1, 5'd5, 1'b1, 5'd5);
    result_vd = 128'h0123456789ABCDEF0123456789ABCDEF;
    result_byte_enable = 16'hFFFF;
    #1;
    chk("single pre write_valid", write_valid, 1'b0);
    chk("single pre empty", empty, 1'b1);
    chk("single pre query_pending", query_pending, 1'b0);
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
    #1;
    chk("single write_valid", write_valid, 1'b1);
    chk("single write_data", write_data, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("single write_address", write_address, 5'd5);
    chk("single write_byte_enable", write_byte_enable, 16'hFFFF);
    chk("single occupancy", occupancy, 3'd1);
    chk("single query_pending", query_pending, 1'b1);
    @(negedge clock);
    #1;
    chk_head("single post", 1'b0, 5'd0, 3'd0);
    chk("single post query_pending", query_pending, 1'b0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      drive(tbl[i].fl, tbl[i].rv, tbl[i].ra, tbl[i].wr, tbl[i].qa);
      #1;
      chk_head($sformatf("vec%0d", i), tbl[i].e_wv, tbl[i].e_wa, tbl[i].e_occ);
      chk($sformatf("vec%0d result_ready", i), result_ready, tbl[i].e_rr);
      chk($sformatf("vec%0d query_pending", i), query_pending, tbl[i].e_qp);
    end

    // concurrent push/pop at occupancy 2 across pointer wrap
    @(negedge clock);
    drive(1'b0, 1'b1, 5'd10, 1'b0, 5'd0);
    @(negedge clock);
    drive(1'b0, 1'b1, 5'd11, 1'b0, 5'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, 5'(12 + i), 1'b1, 5'd0);
      #1;
      chk_head($sformatf("conc%0d", i), 1'b1, 5'(10 + i), 3'd2);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd0);
    #1;
    chk_head("conc drain0", 1'b1, 5'd18, 3'd2);
    @(negedge clock);
    #1;
    chk_head("conc drain1", 1'b1, 5'd19, 3'd1);
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk_head("conc done", 1'b0, 5'd0, 3'd0);

    // flush during simultaneous push and pop at occupancy 3
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, 5'(20 + i), 1'b0, 5'd0);
    end
    @(negedge clock);
    drive(1'b1, 1'b1, 5'd23, 1'b1, 5'd20);
    #1;
    chk_head("flush pre", 1'b1, 5'd20, 3'd3);
    chk("flush pre result_ready", result_ready, 1'b1);
    chk("flush pre query_pending", query_pending, 1'b1);
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd23);
    #1;
    chk_head("flush post", 1'b0, 5'd0, 3'd0);
    chk("flush post query_pending", query_pending, 1'b0);
    @(negedge clock);
    #1;
    chk_head("flush idle", 1'b0, 5'd0, 3'd0);

    // reset while full with write_ready high
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, 5'(24 + i), 1'b0, 5'd0);
    end
    @(negedge clock);
    drive(1'b0, 1'b1, 5'd28, 1'b1, 5'd24);
    reset = 1'b1;
    #1;
    chk_head("rstfull pre", 1'b1, 5'd24, 3'd4);
    chk("rstfull pre result_ready", result_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd24);
    #1;
    chk_head("rstfull post", 1'b0, 5'd0, 3'd0);
    chk("rstfull post query_pending", query_pending, 1'b0);
    chk("rstfull post result_ready", result_ready, 1'b1);
    @(negedge clock);
    drive(1'b0, 1'b1, 5'd2, 1'b0, 5'd2);
    #1;
    chk("rstpush pre write_valid", write_valid, 1'b0);
    chk("rstpush pre query_pending", query_pending, 1'b0);
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd2);
    #1;
    chk_head("rstpush", 1'b1, 5'd2, 3'd1);
    chk("rstpush query_pending", query_pending, 1'b1);
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd2);
    #1;
    chk_head("rstpush done", 1'b0, 5'd0, 3'd0);
    chk("rstpush done query_pending", query_pending, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_result_writeback_buffer.md
Name: vector_result_writeback_buffer

Overview:
Sits directly downstream of the vector floating-point merge unit and the other combinational vector execution units. It captures each produced vd result with its destination register index and byte enables, and buffers it in a small in-order FIFO. It drains the buffered results to the vector register file write port over a valid/ready handshake. It also answers a combinational pending-write query so issue logic can stall on RAW hazards against results not yet written back.

Parameters:
VLEN, 128, vector register width in bits; must be a multiple of 64.
DEPTH, 4, number of FIFO entries; power of two, at least 2.
REG_ADDR_WIDTH, 5, vector register index width.

Ports:
clock  input  1  single system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous discard of all buffered entries.
result_valid  input  1  execution stage presents a result.
result_ready  output  1  buffer accepts the result this cycle.
result_vd  input  VLEN  result vector (merge unit vd).
result_address  input  REG_ADDR_WIDTH  destination register index.
result_byte_enable  input  VLEN/8  per-byte write enable (mask/tail policy already applied).
write_valid  output  1  head entry presented to register file.
write_ready  input  1  register file accepts head entry.
write_data  output  VLEN  head entry vector.
write_address  output  REG_ADDR_WIDTH  head entry register index.
write_byte_enable  output  VLEN/8  head entry byte enables.
query_address  input  REG_ADDR_WIDTH  register index checked by issue logic.
query_pending  output  1  some buffered entry targets query_address.
occupancy  output  $clog2(DEPTH)+1  number of valid entries.
full  output  1  occupancy == DEPTH.
empty  output  1  occupancy == 0.

Behaviour:
- Storage: DEPTH entries of {vd, address, byte_enable, valid}. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is kept separately.
- Push: result_valid && result_ready. Pop: write_valid && write_ready.
- result_ready = !full, combinational. There is no same-cycle bypass, so a push is refused when full even if a pop occurs that cycle.
- write_valid = !empty. write_data, write_address and write_byte_enable are driven from the head entry (first-word-fall-through).
- Latency: a result pushed into an empty buffer at edge N is presented on the write port in the cycle following edge N. It is never presented in the same cycle it is offered.
- While write_valid && !write_ready, the head entry and all write_* outputs hold stable.
- Simultaneous push and pop on a non-full, non-empty buffer: occupancy is unchanged and both pointers advance.
- Push only: occupancy +1. Pop only: occupancy −1.
- The FIFO is strictly in order, including multiple entries to the same address. Later entries overwrite earlier ones at the register file in arrival order.
- An entry with all-zero byte enables is still buffered and popped normally; no filtering is done.
- flush: at the next edge, pointers, occupancy and all valid bits clear. Flush has priority over a simultaneous push and pop; neither takes effect. result_ready is not gated by flush.
- query_pending = OR over valid entries of (entry.address == query_address). It is purely combinational on stored state, and a result being pushed in the same cycle is not included. It deasserts in the cycle after the last matching entry pops.
- Reset (synchronous, active-high, any point including mid-drain):
  - Pointers, occupancy and valid bits clear.
  - Reset values: write_valid=0, write_data=0, write_address=0, write_byte_enable=0, query_pending=0, occupancy=0, full=0, empty=1, result_ready=1 once reset deasserts.
  - Data storage need not be cleared, but write_* outputs must read zero whenever empty.
- reset dominates flush.
- No X may propagate to outputs while empty.

Test Plan:
- Single push into an empty buffer, with write_ready held 1: result_vd=128'h0123…CDEF, address=5, byte_enable=16'hFFFF at edge 1 → write_valid=1 with matching data in cycle 2, empty=1 after edge 2, occupancy 0→1→0.
- Fill and backpressure with write_ready=0: push addresses 1,2,3,4 → full=1, result_ready=0, occupancy=4; a 5th push with address 9 is refused. Release write_ready → addresses pop in order 1,2,3,4, head data stable during stall.
- Concurrent push and pop at occupancy 2: occupancy stays 2 over 8 cycles; 8 consecutive distinct addresses emerge in order, exercising pointer wrap-around twice.
- Hazard query: buffer address 7 twice, then address 3; query_address=7 → pending=1 until the second address-7 entry pops, then 0; query_address=12 → always 0.
- Flush during simultaneous push and pop at occupancy 3 → next cycle occupancy=0, empty=1, write_valid=0, and the pushed entry is absent.
- Assert reset while full and write_ready=1 → next cycle all outputs at reset values. After deassert, a push of address 2 appears one cycle later.
